mul_operand_queue: RTL and testbench
====================================

# mul_operand_queue

Operand staging stage directly upstream of `shift_add_multiply`. Buffers up to DEPTH multiplier/multiplicand pairs from a producer over a valid/ready push port. Issues them to the multiplier one at a time: drives `multiplier`/`multiplicand`, pulses `start` for one cycle, holds the operands stable until the multiplier returns `mul_done`. Decouples operand producers from the multiplier's multi-cycle latency.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2
- `WIDTH`, 32: operand width, matches multiplier operands
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `push_valid`  in  1  producer offers a pair
- `push_ready`  out  1  queue can accept; `!full`, combinational from registered count
- `push_multiplier`  in  WIDTH  operand A
- `push_multiplicand`  in  WIDTH  operand B
- `multiplier`  out  WIDTH  registered operand A to multiplier
- `multiplicand`  out  WIDTH  registered operand B to multiplier
- `start`  out  1  registered one-cycle issue pulse
- `mul_done`  in  1  multiplier completion, one-cycle pulse
- `busy`  out  1  high while a multiplication is in flight (state WAIT)
- `level`  out  $clog2(DEPTH)+1  entries currently queued (excludes in-flight pair)
- `drop_cnt`  out  16  rejected pushes; present only with OPQ_DROP_CNT_EN

## Operation
- Push accepted at a rising edge when `push_valid && push_ready`. Entry written at tail, `level`+1.
- FSM states: IDLE, WAIT.
- IDLE, queue non-empty, at edge:
  - head → `multiplier`/`multiplicand`
  - `start`<=1
  - pop head
  - → WAIT
- IDLE, queue empty: hold. `start`=0, operand outputs keep last issued values.
- WAIT: `start`<=0 after its single cycle. Operand outputs frozen.
  - `mul_done` sampled high, in any WAIT cycle other than the `start` cycle → IDLE.
- `mul_done` is ignored in the cycle `start`=1, and ignored in IDLE.
- Issue order strictly FIFO. No reordering, no operand modification.
- Simultaneous push and pop at one edge: `level` unchanged. Pointers wrap modulo DEPTH.
- Full (`level`==DEPTH): `push_ready`=0, producer stalls, contents preserved.
- Empty: no pop. A push into an empty queue is not popped in the same edge.
- Reset values, all outputs and state:
  - `start`=0, `multiplier`=0, `multiplicand`=0
  - `busy`=0, `level`=0, `push_ready`=1, `drop_cnt`=0
  - FSM IDLE, pointers 0
- `rst` asserted mid-operation: queued and in-flight pairs are discarded immediately. A later `mul_done` from the abandoned operation is ignored (arrives in IDLE).

## Timing
- Push into empty queue with FSM in IDLE:
  - accepted at edge E0
  - `start`=1 and operands valid after edge E1 (one-cycle latency)
  - `level` returns to 0 after E1
- `start` width exactly one clock.
- Operands stable from the `start` cycle through the `mul_done` cycle inclusive.
- Back-to-back issue: `mul_done` sampled at edge D → IDLE. Next `start` rises after edge D+1, so there is a minimum 2-cycle gap from `mul_done` to the next `start`.
- `busy` = registered (state==WAIT). It rises with `start` and falls after the edge sampling `mul_done`.

## Configuration
- `OPQ_DROP_CNT_EN` defined:
  - `drop_cnt` port exists
  - increments at every edge with `push_valid && !push_ready`
  - saturates at 16'hFFFF, cleared only by `rst`
- Undefined: port and counter absent. A stalled push is not counted. All other behaviour is identical.

## Structure
- Shared package `mul_opq_pkg`:
  - FSM state encoding (`OPQ_IDLE`=1'b0, `OPQ_WAIT`=1'b1)
  - `OPQ_DROP_CNT_W`=16
- Sub-module `opq_fifo`: DEPTH×(2·WIDTH) storage, read/write pointers, count, full/empty. Its synchronous push/pop inputs are driven by the top. The FSM and output registers live in `mul_operand_queue`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → immediately `start`=0, `multiplier`=0, `multiplicand`=0, `level`=0, `busy`=0, `push_ready`=1.
- Single issue: push (3,4) into empty idle queue → `start` high exactly one cycle, one cycle after acceptance; `multiplier`=3, `multiplicand`=4 held until `mul_done` pulsed 5 cycles later; `busy` then falls.
- Fill/stall: `mul_done` held low, push (1,1)…(6,6) → (1,1) issued, `level` reaches 4, `push_ready`=0; (6,6) held off. With OPQ_DROP_CNT_EN, `drop_cnt` counts each stalled cycle.
- Drain order: pulse `mul_done` 3 cycles after each `start` → pairs issue in order (2,2),(3,3),(4,4),(5,5),(6,6); each `start` exactly 2 cycles after the preceding `mul_done`.
- Corner events: `mul_done`=1 during the `start` cycle → ignored, stays WAIT. Push and pop on the same edge at `level`=1 → `level` stays 1.
- Reset in WAIT with 2 queued → `level`=0, `busy`=0. A subsequent `mul_done` pulse produces no `start`.

Source files
------------

// File: rtl/mul_opq_pkg.sv
// Shared types for the multiplier operand queue: FSM encoding and drop counter width.
package mul_opq_pkg;

  typedef enum logic {
    OPQ_IDLE = 1'b0,
    OPQ_WAIT = 1'b1
  } opq_state_t;

  localparam int OPQ_DROP_CNT_W = 16;

endpackage

// File: rtl/mul_operand_queue_if.sv
// Producer push port of the operand queue, grouped for connection as one bundle.
interface mul_operand_queue_if #(
  parameter int WIDTH = 32
);
  // A pair transfers at a rising edge where push_valid && push_ready; the producer
  // holds push_valid and both operands stable until that edge, and push_ready
  // never depends on push_valid.
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_multiplier;
  logic [WIDTH-1:0] push_multiplicand;

  modport master (
    output push_valid,
    output push_multiplier,
    output push_multiplicand,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_multiplier,
    input  push_multiplicand,
    output push_ready
  );
endinterface

// File: rtl/opq_fifo.sv
// Circular operand-pair store with occupancy count; push/pop are qualified by the caller.
module opq_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/mul_operand_queue.sv
// Operand staging queue feeding a multi-cycle multiplier, one pair in flight at a time.
// Optional rejected-push counter on drop_cnt when OPQ_DROP_CNT_EN is defined.
module mul_operand_queue
  import mul_opq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  mul_operand_queue_if.slave        push,
  output logic [WIDTH-1:0]          multiplier,
  output logic [WIDTH-1:0]          multiplicand,
  output logic                      start,
  input  logic                      mul_done,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output opq_state_t                state
`ifdef OPQ_DROP_CNT_EN
  ,
  output logic [OPQ_DROP_CNT_W-1:0] drop_cnt
`endif
);
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic [2*WIDTH-1:0] head;
  opq_state_t         state_q;
  opq_state_t         state_d;

  assign push.push_ready = !full;
  assign do_push         = push.push_valid && !full;

  opq_fifo #(
    .DEPTH (DEPTH),
    .DW    (2*WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .wdata ({push.push_multiplier, push.push_multiplicand}),
    .rdata (head),
    .count (level),
    .full  (full),
    .empty (empty)
  );

  // mul_done is only honoured once the start pulse has retired.
  always_comb begin
    state_d = state_q;
    do_pop  = 1'b0;
    case (state_q)
      OPQ_IDLE: begin
        if (!empty) begin
          do_pop  = 1'b1;
          state_d = OPQ_WAIT;
        end
      end
      OPQ_WAIT: begin
        if (mul_done && !start) state_d = OPQ_IDLE;
      end
      default: state_d = OPQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= OPQ_IDLE;
      start        <= 1'b0;
      multiplier   <= '0;
      multiplicand <= '0;
    end else begin
      state_q <= state_d;
      start   <= do_pop;
      if (do_pop) {multiplier, multiplicand} <= head;
    end
  end

  assign busy  = (state_q == OPQ_WAIT);
  assign state = state_q;

`ifdef OPQ_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (push.push_valid && full && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + OPQ_DROP_CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_mul_operand_queue.sv
// Directed bench for mul_operand_queue: reset, issue timing, fill/stall, drain order, corners.
module tb_mul_operand_queue;
  import mul_opq_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   mul_done;
  logic [WIDTH-1:0]       multiplier;
  logic [WIDTH-1:0]       multiplicand;
  logic                   start;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;
  opq_state_t             state;
`ifdef OPQ_DROP_CNT_EN
  logic [15:0]            drop_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  mul_operand_queue_if #(.WIDTH(WIDTH)) push_if ();

  mul_operand_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push_if.slave),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .start        (start),
    .mul_done     (mul_done),
    .busy         (busy),
    .level        (level),
    .state        (state)
`ifdef OPQ_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock; an accepted push is withdrawn so each pair enters exactly once.
  task automatic step();
    logic acc;
    acc = push_if.push_valid && push_if.push_ready;
    @(posedge clk);
    #1;
    if (acc) push_if.push_valid = 1'b0;
  endtask

  task automatic offer(input int a, input int b);
    push_if.push_multiplier   = WIDTH'(a);
    push_if.push_multiplicand = WIDTH'(b);
    push_if.push_valid        = 1'b1;
  endtask

  task automatic test_reset();
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL rst_start got %0h exp 0", start); end
    vectors++; if (multiplier !== '0) begin miscompares++; $display("FAIL rst_mplier got %0h exp 0", multiplier); end
    vectors++; if (multiplicand !== '0) begin miscompares++; $display("FAIL rst_mcand got %0h exp 0", multiplicand); end
    vectors++; if (level !== '0) begin miscompares++; $display("FAIL rst_level got %0d exp 0", level); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0h exp 0", busy); end
    vectors++; if (push_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %0h exp 1", push_if.push_ready); end
    vectors++; if (state !== OPQ_IDLE) begin miscompares++; $display("FAIL rst_state got %0h exp 0", state); end
`ifdef OPQ_DROP_CNT_EN
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
`endif
    offer(7, 8);
    step();
    step();
    vectors++; if (start !== 1'b1 || multiplier !== 32'd7) begin miscompares++; $display("FAIL pre_rst_issue got start=%0h a=%0d exp 1,7", start, multiplier); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL async_rst_start got %0h exp 0", start); end
    vectors++; if (multiplier !== '0 || multiplicand !== '0) begin miscompares++; $display("FAIL async_rst_ops got %0d,%0d exp 0,0", multiplier, multiplicand); end
    vectors++; if (level !== '0 || busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_lvl_busy got %0d,%0h exp 0,0", level, busy); end
    vectors++; if (push_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL async_rst_ready got %0h exp 1", push_if.push_ready); end
    #1 rst = 1'b0;
  endtask

  task automatic test_single_issue();
    offer(3, 4);
    step();
    vectors++; if (level !== 3'd1 || start !== 1'b0) begin miscompares++; $display("FAIL single_accept got lvl=%0d start=%0h exp 1,0", level, start); end
    step();
    vectors++; if (start !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL single_start got start=%0h busy=%0h exp 1,1", start, busy); end
    vectors++; if (multiplier !== 32'd3 || multiplicand !== 32'd4) begin miscompares++; $display("FAIL single_ops got %0d,%0d exp 3,4", multiplier, multiplicand); end
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL single_level got %0d exp 0", level); end
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++; if (start !== 1'b0 || busy !== 1'b1 || multiplier !== 32'd3 || multiplicand !== 32'd4) begin
        miscompares++; $display("FAIL single_hold[%0d] got start=%0h busy=%0h ops=%0d,%0d exp 0,1,3,4", i, start, busy, multiplier, multiplicand);
      end
    end
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    vectors++; if (busy !== 1'b0 || multiplier !== 32'd3 || multiplicand !== 32'd4) begin miscompares++; $display("FAIL single_done got busy=%0h ops=%0d,%0d exp 0,3,4", busy, multiplier, multiplicand); end
    step();
    step();
    vectors++; if (start !== 1'b0 || busy !== 1'b0 || multiplier !== 32'd3) begin miscompares++; $display("FAIL idle_hold got start=%0h busy=%0h a=%0d exp 0,0,3", start, busy, multiplier); end
  endtask

  task automatic test_fill_stall();
    for (int k = 1; k <= 5; k++) begin
      offer(k, k);
      step();
      if (k == 2) begin
        vectors++; if (start !== 1'b1 || multiplier !== 32'd1 || multiplicand !== 32'd1) begin miscompares++; $display("FAIL fill_first_issue got start=%0h ops=%0d,%0d exp 1,1,1", start, multiplier, multiplicand); end
      end
    end
    vectors++; if (level !== 3'd4 || push_if.push_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full got lvl=%0d ready=%0h exp 4,0", level, push_if.push_ready); end
    offer(6, 6);
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++; if (level !== 3'd4 || push_if.push_ready !== 1'b0 || busy !== 1'b1 || multiplier !== 32'd1) begin
        miscompares++; $display("FAIL stall[%0d] got lvl=%0d ready=%0h busy=%0h a=%0d exp 4,0,1,1", i, level, push_if.push_ready, busy, multiplier);
      end
    end
`ifdef OPQ_DROP_CNT_EN
    vectors++; if (drop_cnt !== 16'd3) begin miscompares++; $display("FAIL stall_drop got %0d exp 3", drop_cnt); end
`endif
  endtask

  task automatic test_drain_order();
    int n;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_first_done got busy=%0h exp 0", busy); end
    for (int k = 2; k <= 6; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (start !== 1'b1 && n < 8);
      vectors++; if (n != 1) begin miscompares++; $display("FAIL drain_gap[%0d] got %0d cycles exp 1 after done edge", k, n); end
      vectors++; if (multiplier !== 32'(k) || multiplicand !== 32'(k)) begin miscompares++; $display("FAIL drain_order[%0d] got %0d,%0d exp %0d,%0d", k, multiplier, multiplicand, k, k); end
      step();
      vectors++; if (start !== 1'b0) begin miscompares++; $display("FAIL drain_pulse[%0d] got start=%0h exp 0", k, start); end
      step();
      mul_done = 1'b1;
      step();
      mul_done = 1'b0;
      vectors++; if (busy !== 1'b0 || multiplier !== 32'(k)) begin miscompares++; $display("FAIL drain_done[%0d] got busy=%0h a=%0d exp 0,%0d", k, busy, multiplier, k); end
    end
    vectors++; if (level !== 3'd0 || push_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL drain_empty got lvl=%0d ready=%0h exp 0,1", level, push_if.push_ready); end
`ifdef OPQ_DROP_CNT_EN
    vectors++; if (drop_cnt !== 16'd5) begin miscompares++; $display("FAIL drain_drop got %0d exp 5", drop_cnt); end
`endif
  endtask

  task automatic test_corner();
    offer(9, 10);
    step();
    step();
    vectors++; if (start !== 1'b1 || multiplier !== 32'd9 || multiplicand !== 32'd10) begin miscompares++; $display("FAIL corner_issue got start=%0h ops=%0d,%0d exp 1,9,10", start, multiplier, multiplicand); end
    mul_done = 1'b1;
    offer(11, 12);
    step();
    mul_done = 1'b0;
    vectors++; if (busy !== 1'b1 || start !== 1'b0 || level !== 3'd1) begin miscompares++; $display("FAIL done_in_start got busy=%0h start=%0h lvl=%0d exp 1,0,1", busy, start, level); end
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    vectors++; if (busy !== 1'b0 || level !== 3'd1) begin miscompares++; $display("FAIL corner_done got busy=%0h lvl=%0d exp 0,1", busy, level); end
    offer(13, 14);
    step();
    vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL push_pop_level got %0d exp 1", level); end
    vectors++; if (start !== 1'b1 || multiplier !== 32'd11 || multiplicand !== 32'd12) begin miscompares++; $display("FAIL push_pop_issue got start=%0h ops=%0d,%0d exp 1,11,12", start, multiplier, multiplicand); end
  endtask

  task automatic test_reset_in_wait();
    offer(20, 20);
    step();
    vectors++; if (level !== 3'd2 || busy !== 1'b1) begin miscompares++; $display("FAIL wait_two_queued got lvl=%0d busy=%0h exp 2,1", level, busy); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (level !== 3'd0 || busy !== 1'b0 || start !== 1'b0) begin miscompares++; $display("FAIL wait_rst got lvl=%0d busy=%0h start=%0h exp 0,0,0", level, busy, start); end
    vectors++; if (multiplier !== '0 || push_if.push_ready !== 1'b1) begin miscompares++; $display("FAIL wait_rst_ops got a=%0d ready=%0h exp 0,1", multiplier, push_if.push_ready); end
    #1 rst = 1'b0;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      vectors++; if (start !== 1'b0 || busy !== 1'b0 || level !== 3'd0) begin
        miscompares++; $display("FAIL stale_done[%0d] got start=%0h busy=%0h lvl=%0d exp 0,0,0", i, start, busy, level);
      end
      step();
    end
  endtask

  initial begin
    rst                       = 1'b1;
    mul_done                  = 1'b0;
    push_if.push_valid        = 1'b0;
    push_if.push_multiplier   = '0;
    push_if.push_multiplicand = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_issue();
    test_fill_stall();
    test_drain_order();
    test_corner();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
